sd_tx_block_serializer: RTL
===========================

Name: sd_tx_block_serializer

Overview:
- Downstream consumer of the TX FIFO that the WB filler loads.
- Runs in the SD card clock domain and pops 32-bit words from the FIFO read port.
- Frames each block onto the SD DAT lines: start bit, payload, per-lane CRC16, end bit.
- After each block, releases the bus and waits out the card's CRC-status/busy period before starting the next block.

Parameters:
- BLK_BYTES, 512, bytes per block; must be a multiple of 4; WPB = BLK_BYTES/4 words per block.
- GAP_CYC, 8, cycles the bus stays released after the end bit before DAT0 busy is sampled.

Ports:
- clk  in  1  SD card clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a transfer; ignored unless busy=0.
- stop  in  1  abort request; honoured in any non-IDLE state.
- wide_bus  in  1  1 = 4-bit mode on DAT[3:0]; 0 = 1-bit mode on DAT[0]. Sampled at start.
- blk_cnt  in  16  number of blocks, latched at start; 0 is treated as 1.
- dat_i  in  32  FIFO read data, valid the cycle after rd.
- empty  in  1  FIFO empty flag.
- rd  out  1  FIFO pop strobe, one cycle per word.
- dat_o  out  4  DAT line drive values.
- dat_oe  out  1  DAT output enable.
- dat0_i  in  1  DAT0 sampled from pad; 0 = card busy.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse on normal completion.
- underrun  out  1  sticky; cleared by the next accepted start.
- crc_busy_err  out  1  sticky; set when GAP_CYC expires with dat0_i not yet sampled; cleared by start.

Behaviour:
- Reset values: rd=0, dat_o=4'hF, dat_oe=0, busy=0, done=0, underrun=0, crc_busy_err=0, state IDLE.
- States:
  - IDLE → FETCH on start.
  - FETCH: wait while empty. Once !empty, rd=1 for one cycle → LOAD.
  - LOAD: shift register ← dat_i; clear the 4 lane CRCs to 0 → START.
  - START: dat_oe=1; dat_o=0 on active lanes (lane 0 only when wide_bus=0; lanes 3:1 stay 1) → DATA.
  - DATA: one slot per cycle. 4-bit mode: 8 slots/word, DAT3..DAT0 = sr[31:28], then sr <<= 4. 1-bit mode: 32 slots/word, DAT0 = sr[31], then sr <<= 1.
  - CRC: 16 cycles. Each active lane sends its own CRC16 (x^16+x^12+x^5+1), MSB first. The CRC covers only the data bits on that lane.
  - END: one cycle, all lanes 1, dat_oe=1 → GAP.
  - GAP: dat_oe=0 for GAP_CYC cycles → BUSYW.
  - BUSYW: wait while dat0_i=0. When dat0_i=1: if blocks remain, go to FETCH; otherwise pulse done and go to IDLE.
- Prefetch in DATA:
  - In the second-to-last slot of a word, if more words remain in the block and !empty, assert rd. The new word is loaded into sr at the last slot's transition, so the stream has no gap.
  - If empty at that slot, set underrun and abort.
  - Word count wraps per block at WPB. The block counter decrements at END.
- Abort (underrun or stop): next cycle dat_oe=0, dat_o=4'hF, rd=0, state IDLE, no done. A FIFO word already popped is discarded.
- Simultaneous events: stop has priority over underrun. start while busy is ignored. stop in IDLE has no effect.
- Reset mid-transfer: all outputs take their reset values asynchronously.
- rd is never asserted when empty=1.

Test Plan:
- 4-bit, BLK_BYTES=512, blk_cnt=1, FIFO preloaded with 128 words 0x00000000..0x0000007F:
  - start bit occurs 3 cycles after start.
  - 1024 data slots, then 16 CRC cycles, then end bit; rd pulses exactly 128 times.
  - dat0_i high after GAP → done pulses once; the per-lane CRC matches the model.
- 1-bit, one word 0xA5A5A5A5 (BLK_BYTES=4):
  - DAT0 shows 0, 1,0,1,0,0,1,0,1 ... (32 bits), then CRC16, then 1.
  - DAT3..1 stay 1 and dat_oe=1 throughout.
- FIFO empty at the slot-6 prefetch of word 5 → underrun=1; dat_oe=0 the next cycle; busy=0; no done; the next start clears underrun.
- blk_cnt=2 with dat0_i held 0 for 20 cycles after the first GAP → no rd and dat_oe=0 until dat0_i=1, then the second block starts and done pulses after the second block only.
- stop in cycle 300 of DATA → dat_oe=0 and dat_o=4'hF the next cycle; IDLE; later start accepted normally.
- rst asserted low in the CRC state → dat_oe=0, dat_o=4'hF and busy=0 immediately, without a clock edge.

Source files
------------

// File: rtl/sd_tx_block_serializer.sv
// sd_tx_block_serializer
// Pops 32-bit words from the TX FIFO and frames each block onto the SD DAT
// lines: start bit, payload, one CRC16 per active lane, end bit. After each
// block the bus is released for GAP_CYC cycles. The serializer then waits for
// the card to release DAT0 (busy) before it fetches the next block.
//
// Ports:
//   clk           SD card clock (only clock)
//   rst           asynchronous active-low reset
//   start         one-cycle pulse, accepted only while idle (busy=0)
//   stop          abort request, honoured in any non-idle state
//   wide_bus      1 = 4-bit mode on DAT[3:0], 0 = 1-bit mode on DAT[0]; sampled at start
//   blk_cnt       number of blocks, latched at start (0 behaves as 1)
//   dat_i         FIFO read data, valid the cycle after rd
//   empty         FIFO empty flag
//   rd            FIFO pop strobe, one cycle per word, never while empty
//   dat_o         DAT line drive values (idle value 4'hF)
//   dat_oe        DAT output enable
//   dat0_i        DAT0 from the pad, 0 = card busy
//   busy          high in every non-idle state
//   done          one-cycle pulse after the last block completes normally
//   underrun      sticky, FIFO ran dry mid-block; cleared by the next start
//   crc_busy_err  sticky, DAT0 never seen low during the gap; cleared by start
//   state_dbg     current FSM state encoding, for observation only
//
// Handshake: the FIFO read port is a pop/data pair. rd is asserted only when
// empty=0, and the popped word is captured from dat_i on the following cycle.
module sd_tx_block_serializer #(
  parameter int BLK_BYTES = 512,
  parameter int GAP_CYC   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        wide_bus,
  input  logic [15:0] blk_cnt,
  input  logic [31:0] dat_i,
  input  logic        empty,
  output logic        rd,
  output logic [3:0]  dat_o,
  output logic        dat_oe,
  input  logic        dat0_i,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        crc_busy_err,
  output logic [3:0]  state_dbg
);

  localparam int WPB = BLK_BYTES / 4;
  localparam int WW  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [WW-1:0] WORD_LAST = WW'(WPB - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_CRC, S_END, S_GAP, S_BUSYW
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   sr_q;
  logic          wide_q;
  logic [15:0]   blk_left_q;
  logic [4:0]    slot_q;
  logic [WW-1:0] word_q;
  logic [3:0]    crc_cnt_q;
  logic [GW-1:0] gap_q;
  logic          gap_low_q;
  logic [15:0]   crc_q [4];
  logic          done_q;
  logic          underrun_q;
  logic          crc_err_q;

  logic [4:0]    last_slot;
  logic          slot_last;
  logic          word_last;
  logic          pf_slot;
  logic          underrun_hit;
  logic [3:0]    data_nib;

  // One CRC16-CCITT step (x^16 + x^12 + x^5 + 1), register starts at zero.
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ ({16{fb}} & 16'h1021);
  endfunction

  assign last_slot = wide_q ? 5'd7 : 5'd31;
  assign slot_last = (slot_q == last_slot);
  assign word_last = (word_q == WORD_LAST);
  // The pop for the next word goes out one slot early so that the word is on
  // dat_i exactly when the last slot of the current word shifts out.
  assign pf_slot      = (state_q == S_DATA) && (slot_q == last_slot - 5'd1) && !word_last;
  assign underrun_hit = pf_slot && empty && !stop;

  // Lane values of the current payload slot; unused lanes idle high.
  assign data_nib = wide_q ? sr_q[31:28] : {3'b111, sr_q[31]};

  assign rd = !stop && !empty && ((state_q == S_FETCH) || pf_slot);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (!empty) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_DATA;
      S_DATA: begin
        if (underrun_hit)           state_d = S_IDLE;
        else if (slot_last && word_last) state_d = S_CRC;
      end
      S_CRC:   if (crc_cnt_q == 4'd15) state_d = S_END;
      S_END:   state_d = S_GAP;
      S_GAP:   if (gap_q == GAP_LAST) state_d = S_BUSYW;
      S_BUSYW: if (dat0_i) state_d = (blk_left_q != 16'd0) ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q       <= '0;
      wide_q     <= 1'b0;
      blk_left_q <= '0;
      slot_q     <= '0;
      word_q     <= '0;
      crc_cnt_q  <= '0;
      gap_q      <= '0;
      gap_low_q  <= 1'b0;
      for (int l = 0; l < 4; l++) crc_q[l] <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_BUSYW) && dat0_i && (blk_left_q == 16'd0) && !stop;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            wide_q     <= wide_bus;
            blk_left_q <= (blk_cnt == 16'd0) ? 16'd1 : blk_cnt;
            underrun_q <= 1'b0;
            crc_err_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          sr_q      <= dat_i;
          slot_q    <= '0;
          word_q    <= '0;
          crc_cnt_q <= '0;
          for (int l = 0; l < 4; l++) crc_q[l] <= '0;
        end
        S_DATA: begin
          for (int l = 0; l < 4; l++) crc_q[l] <= crc_next(crc_q[l], data_nib[l]);
          if (underrun_hit) underrun_q <= 1'b1;
          if (slot_last) begin
            slot_q <= '0;
            if (!word_last) begin
              sr_q   <= dat_i;
              word_q <= word_q + 1'b1;
            end
          end else begin
            slot_q <= slot_q + 5'd1;
            sr_q   <= wide_q ? {sr_q[27:0], 4'h0} : {sr_q[30:0], 1'b0};
          end
        end
        S_CRC: begin
          for (int l = 0; l < 4; l++) crc_q[l] <= {crc_q[l][14:0], 1'b0};
          crc_cnt_q <= crc_cnt_q + 4'd1;
        end
        S_END: begin
          blk_left_q <= blk_left_q - 16'd1;
          gap_q      <= '0;
          gap_low_q  <= 1'b0;
        end
        S_GAP: begin
          gap_q <= gap_q + 1'b1;
          if (!dat0_i) gap_low_q <= 1'b1;
          // The card must show CRC status / busy on DAT0 somewhere in the gap.
          if ((gap_q == GAP_LAST) && !stop && !gap_low_q && dat0_i) crc_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dat_oe = 1'b0;
    dat_o  = 4'hF;
    case (state_q)
      S_START: begin
        dat_oe = 1'b1;
        dat_o  = wide_q ? 4'h0 : 4'hE;
      end
      S_DATA: begin
        dat_oe = 1'b1;
        dat_o  = data_nib;
      end
      S_CRC: begin
        dat_oe = 1'b1;
        dat_o  = wide_q ? {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]}
                        : {3'b111, crc_q[0][15]};
      end
      S_END: begin
        dat_oe = 1'b1;
        dat_o  = 4'hF;
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign underrun     = underrun_q;
  assign crc_busy_err = crc_err_q;
  assign state_dbg    = state_q;

endmodule
